spi_flash_reader: RTL and testbench
===================================

SPI_FLASH_READER -- requirements
Module: spi_flash_reader

Interface
REQ-001 The module SHALL have parameter CLK_DIV, default 2, meaning SCK half-period in clk cycles (legal range 1..255).
REQ-002 The module SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The module SHALL have port req_valid, input, 1 bit: a read request is presented.
REQ-005 The module SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-006 The module SHALL have port req_addr, input, 24 bits: flash start byte address.
REQ-007 The module SHALL have port req_len, input, 16 bits: number of bytes to read.
REQ-008 The module SHALL have port rd_data, output, 8 bits: received flash byte.
REQ-009 The module SHALL have port rd_valid, output, 1 bit: one-cycle strobe that rd_data is valid.
REQ-010 The module SHALL have port done, output, 1 bit: one-cycle strobe when a request completes.
REQ-011 The module SHALL have port spi_cs, output, 1 bit: chip select, active low (1 = deselected).
REQ-012 The module SHALL have port spi_sck, output, 1 bit: SPI clock, mode 0.
REQ-013 The module SHALL have port spi_mosi, output, 1 bit: data to flash, MSB first.
REQ-014 The module SHALL have port spi_miso, input, 1 bit: data from flash, MSB first.

Function
REQ-015 A request SHALL be accepted on the cycle where req_valid && req_ready; req_addr and req_len SHALL be latched on that cycle.
REQ-016 req_ready SHALL be 1 only in IDLE, and SHALL be 0 on the acceptance cycle's following cycle onward.
REQ-017 The FSM SHALL have states IDLE -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
REQ-018 Accepting a request with req_len == 0 SHALL leave spi_cs high, pulse done on the next cycle, and remain in IDLE.
REQ-019 Accepting a request with req_len != 0 SHALL drive spi_cs low on the next cycle and enter SETUP.
REQ-020 In SETUP, spi_sck SHALL be 0 and spi_mosi SHALL equal bit 7 of 0x03; after CLK_DIV cycles the FSM SHALL enter SHIFT.
REQ-021 SHIFT SHALL send 32 header bits: 0x03, then req_addr[23:16], req_addr[15:8], req_addr[7:0], MSB first.
REQ-022 Each SHIFT bit SHALL hold spi_sck at 1 for CLK_DIV cycles, then at 0 for CLK_DIV cycles.
REQ-023 spi_mosi SHALL change only on the cycle spi_sck goes 1->0.
REQ-024 spi_mosi SHALL be 0 after the 32 header bits.
REQ-025 After the header, SHIFT SHALL clock 8*req_len data bits, sampling spi_miso on the cycle spi_sck goes 0->1.
REQ-026 After each 8th sampled data bit, rd_data SHALL hold the assembled byte and rd_valid SHALL pulse on the next cycle.
REQ-027 Bytes SHALL be delivered in address order; rd_valid SHALL pulse exactly req_len times per request.
REQ-028 No backpressure SHALL exist on rd_data; the consumer SHALL be able to accept one byte per 16*CLK_DIV cycles.
REQ-029 After the last data bit's low half-period, the FSM SHALL enter HOLD with spi_sck 0 and spi_cs 0 for CLK_DIV cycles.
REQ-030 On leaving HOLD, spi_cs SHALL go high and done SHALL pulse in the same cycle; the FSM SHALL then enter GAP.
REQ-031 GAP SHALL keep spi_cs high for CLK_DIV cycles before returning to IDLE, guaranteeing minimum deselect time.
REQ-032 The bit counter SHALL be 3 bits plus a 16-bit byte down-counter; req_len 0xFFFF SHALL deliver 65535 bytes without wrap.
REQ-033 Flash address rollover past 0xFFFFFF SHALL be left to the flash; the block SHALL not modify the address.
REQ-034 Exactly 32 + 8*req_len rising SCK edges SHALL occur while spi_cs is low.

Reset
REQ-035 While reset is 1, the following SHALL hold on the next clk edge: spi_cs=1, spi_sck=0, spi_mosi=0, rd_valid=0, done=0, rd_data=0, req_ready=0, FSM=IDLE.
REQ-036 In the cycle after reset is released, req_ready SHALL be 1.
REQ-037 Reset mid-transfer SHALL abort the transfer with no further rd_valid and no done pulse.

Verification
REQ-038 Scenario (CLK_DIV=2): addr 0x123456, len 2, flash model returns 0xA5, 0x3C -> MOSI bits 0x03 12 34 56; rd_valid twice with 0xA5 then 0x3C; 48 SCK rising edges; one done pulse.
REQ-039 Scenario: len 0 -> spi_cs never low; done one cycle after acceptance; no rd_valid.
REQ-040 Scenario (CLK_DIV=1): addr 0xFFFFFF, len 1, MISO constant 1 -> rd_data 0xFF; SCK period 2 clk; cs low-to-high span = 1 + 40*2 + 1 cycles.
REQ-041 Scenario: reset asserted after 10 data bits -> spi_cs=1 and spi_sck=0 the next cycle; no rd_valid or done afterwards.
REQ-042 Scenario: req_valid held high continuously -> after done, spi_cs stays high at least CLK_DIV cycles before the second transfer's cs falls; req_ready low throughout each transfer.
REQ-043 Scenario: checker on all runs -> MOSI never toggles while SCK is 1; SCK is 0 whenever cs is 1.

Source files
------------

// File: rtl/spi_flash_reader.sv
// SPI NOR flash reader: issues READ (0x03) + 24-bit address in SPI mode 0,
// then streams req_len bytes out on rd_data/rd_valid.
module spi_flash_reader #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  input  logic [15:0] req_len,
  output logic [7:0]  rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        spi_cs,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  localparam logic [7:0] CMD  = 8'h03;
  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic [31:0] tx, tx_nx;
  logic [7:0]  rx, rx_nx;
  logic [2:0]  bit_cnt, bit_cnt_nx;
  logic [15:0] byte_cnt, byte_cnt_nx;
  logic [1:0]  hdr_cnt, hdr_cnt_nx;
  logic        hdr, hdr_nx;
  logic        cs_nx, sck_nx, mosi_nx;
  logic        ready_nx, done_nx, rv_nx;
  logic [7:0]  rd_data_nx;
  logic        last;

  assign last = (cnt == LAST);

  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt + 8'd1;
    tx_nx       = tx;
    rx_nx       = rx;
    bit_cnt_nx  = bit_cnt;
    byte_cnt_nx = byte_cnt;
    hdr_cnt_nx  = hdr_cnt;
    hdr_nx      = hdr;
    cs_nx       = spi_cs;
    sck_nx      = spi_sck;
    mosi_nx     = spi_mosi;
    ready_nx    = 1'b0;
    done_nx     = 1'b0;
    rv_nx       = 1'b0;
    rd_data_nx  = rd_data;
    unique case (state)
      IDLE: begin
        cnt_nx   = '0;
        ready_nx = 1'b1;
        if (req_valid && req_ready) begin
          ready_nx = 1'b0;
          if (req_len == 16'd0) begin
            done_nx = 1'b1;
          end else begin
            state_nx    = SETUP;
            cs_nx       = 1'b0;
            sck_nx      = 1'b0;
            mosi_nx     = CMD[7];
            tx_nx       = {CMD, req_addr};
            byte_cnt_nx = req_len;
            bit_cnt_nx  = '0;
            hdr_nx      = 1'b1;
            hdr_cnt_nx  = '0;
          end
        end
      end
      SETUP: begin
        if (last) begin
          state_nx = SHIFT;
          cnt_nx   = '0;
          sck_nx   = 1'b1;
        end
      end
      SHIFT: begin
        if (last) begin
          cnt_nx = '0;
          if (spi_sck) begin
            // falling edge: advance MOSI; zero fill drives 0 after header
            sck_nx     = 1'b0;
            tx_nx      = {tx[30:0], 1'b0};
            mosi_nx    = tx[30];
            bit_cnt_nx = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (hdr) begin
                hdr_cnt_nx = hdr_cnt + 2'd1;
                if (hdr_cnt == 2'd3)
                  hdr_nx = 1'b0;
              end else begin
                byte_cnt_nx = byte_cnt - 16'd1;
              end
            end
          end else if (!hdr && byte_cnt == 16'd0) begin
            state_nx = HOLD;
          end else begin
            sck_nx = 1'b1;
            if (!hdr) begin
              rx_nx = {rx[6:0], spi_miso};
              if (bit_cnt == 3'd7) begin
                rd_data_nx = {rx[6:0], spi_miso};
                rv_nx      = 1'b1;
              end
            end
          end
        end
      end
      HOLD: begin
        if (last) begin
          state_nx = GAP;
          cnt_nx   = '0;
          cs_nx    = 1'b1;
          done_nx  = 1'b1;
        end
      end
      GAP: begin
        if (last) begin
          state_nx = IDLE;
          cnt_nx   = '0;
          ready_nx = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      tx        <= '0;
      rx        <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      hdr_cnt   <= '0;
      hdr       <= 1'b0;
      spi_cs    <= 1'b1;
      spi_sck   <= 1'b0;
      spi_mosi  <= 1'b0;
      req_ready <= 1'b0;
      done      <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      tx        <= tx_nx;
      rx        <= rx_nx;
      bit_cnt   <= bit_cnt_nx;
      byte_cnt  <= byte_cnt_nx;
      hdr_cnt   <= hdr_cnt_nx;
      hdr       <= hdr_nx;
      spi_cs    <= cs_nx;
      spi_sck   <= sck_nx;
      spi_mosi  <= mosi_nx;
      req_ready <= ready_nx;
      done      <= done_nx;
      rd_valid  <= rv_nx;
      rd_data   <= rd_data_nx;
    end
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Bench for spi_flash_reader: flash model, byte scoreboard, SPI protocol
// watchers; one DUT at CLK_DIV=2 and one at CLK_DIV=1.
module tb_spi_flash_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic [23:0] req_addr = '0;
  logic [15:0] req_len = '0;
  logic [7:0]  rd_data;
  logic        rd_valid, done, spi_cs, spi_sck, spi_mosi;
  logic        spi_miso = 1'b0;

  logic        req_valid1 = 1'b0, req_ready1;
  logic [23:0] req_addr1 = '0;
  logic [15:0] req_len1 = '0;
  logic [7:0]  rd_data1;
  logic        rd_valid1, done1, spi_cs1, spi_sck1, spi_mosi1;
  logic        spi_miso1 = 1'b1;

  spi_flash_reader #(.CLK_DIV(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
    .spi_cs(spi_cs), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso)
  );

  spi_flash_reader #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .req_addr(req_addr1), .req_len(req_len1),
    .rd_data(rd_data1), .rd_valid(rd_valid1), .done(done1),
    .spi_cs(spi_cs1), .spi_sck(spi_sck1),
    .spi_mosi(spi_mosi1), .spi_miso(spi_miso1)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp1_q[$];
  logic [7:0] flash_mem[16];

  int rise_cnt = 0, last_rises = 0, rv_cnt = 0, done_cnt = 0;
  int mosi_err = 0, viol = 0, viol1 = 0, ready_err = 0;
  int hi = 0, last_gap = 0, cs_falls = 0, idx = 0;
  logic [31:0] hdr_bits = '0;
  logic [7:0]  e0;
  logic p_sck = 1'b0, p_mosi = 1'b0, p_cs = 1'b1;
  logic p_sck1 = 1'b0, p_mosi1 = 1'b0;

  // protocol watcher, scoreboard and flash model for the CLK_DIV=2 DUT
  always @(negedge clk) begin
    if (p_sck && spi_sck && spi_mosi !== p_mosi) viol++;
    if (spi_cs && spi_sck) viol++;
    if (!spi_cs && req_ready) ready_err++;
    if (p_cs && !spi_cs) begin
      rise_cnt = 0;
      cs_falls++;
      last_gap = hi;
    end
    if (!p_cs && spi_cs) last_rises = rise_cnt;
    if (!p_sck && spi_sck && !spi_cs) begin
      if (rise_cnt < 32) hdr_bits = {hdr_bits[30:0], spi_mosi};
      else if (spi_mosi !== 1'b0) mosi_err++;
      rise_cnt++;
    end
    if (done) begin
      done_cnt++;
      hi = 1;
    end else if (spi_cs) begin
      hi++;
    end
    if (rd_valid) begin
      rv_cnt++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rd_unexpected: got %h, no byte expected", rd_data);
      end else begin
        e0 = exp_q.pop_front();
        if (rd_data !== e0) begin
          fails++;
          $display("FAIL rd_data: got %h, required %h", rd_data, e0);
        end
      end
    end
    idx = rise_cnt - 32;
    if (rise_cnt >= 32 && idx < 128)
      spi_miso = flash_mem[idx >> 3][7 - (idx & 7)];
    else
      spi_miso = 1'b0;
    p_sck  = spi_sck;
    p_mosi = spi_mosi;
    p_cs   = spi_cs;
  end

  always @(negedge clk) begin
    if (p_sck1 && spi_sck1 && spi_mosi1 !== p_mosi1) viol1++;
    if (spi_cs1 && spi_sck1) viol1++;
    p_sck1  = spi_sck1;
    p_mosi1 = spi_mosi1;
  end

  task automatic send(input logic [23:0] a, input logic [15:0] l);
    int n = 0;
    req_addr  = a;
    req_len   = l;
    req_valid = 1'b1;
    for (int i = 0; i < int'(l); i++) exp_q.push_back(flash_mem[i]);
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 200) begin
      fails++;
      $display("FAIL accept_timeout: ready=%b, required 1", req_ready);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (done_cnt < target) begin
      fails++;
      $display("FAIL done_timeout: done count %0d, required %0d",
               done_cnt, target);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if ({spi_cs, spi_sck, spi_mosi, rd_valid, done, req_ready} !== 6'b100000) begin
      fails++;
      $display("FAIL reset_ctl: cs,sck,mosi,rv,done,ready=%b, required 100000",
               {spi_cs, spi_sck, spi_mosi, rd_valid, done, req_ready});
    end
    tests++;
    if (rd_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_rd_data: got %h, required 00", rd_data);
    end
    tests++;
    if ({spi_cs1, spi_sck1, req_ready1} !== 3'b100) begin
      fails++;
      $display("FAIL reset_dut1: cs,sck,ready=%b, required 100",
               {spi_cs1, spi_sck1, req_ready1});
    end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_reset: got %b, required 1", req_ready);
    end
  endtask

  task automatic test_basic();
    int rv0 = rv_cnt;
    int d0 = done_cnt;
    flash_mem[0] = 8'hA5;
    flash_mem[1] = 8'h3C;
    hdr_bits = '0;
    mosi_err = 0;
    send(24'h123456, 16'd2);
    wait_done(d0 + 1, 2000);
    tests++;
    if (hdr_bits !== 32'h03123456) begin
      fails++;
      $display("FAIL basic_header: got %h, required 03123456", hdr_bits);
    end
    tests++;
    if (last_rises !== 48) begin
      fails++;
      $display("FAIL basic_rises: got %0d, required 48", last_rises);
    end
    tests++;
    if (rv_cnt - rv0 !== 2 || done_cnt - d0 !== 1) begin
      fails++;
      $display("FAIL basic_counts: rv=%0d done=%0d, required 2 and 1",
               rv_cnt - rv0, done_cnt - d0);
    end
    tests++;
    if (exp_q.size() != 0 || mosi_err != 0) begin
      fails++;
      $display("FAIL basic_tail: left=%0d mosi_err=%0d, required 0 and 0",
               exp_q.size(), mosi_err);
    end
  endtask

  task automatic test_len_zero();
    int rv0 = rv_cnt;
    int d0 = done_cnt;
    int f0 = cs_falls;
    send(24'h000100, 16'd0);
    @(negedge clk);
    tests++;
    if (done !== 1'b1 || spi_cs !== 1'b1) begin
      fails++;
      $display("FAIL len0_done: done=%b cs=%b, required 1 and 1", done, spi_cs);
    end
    repeat (6) @(negedge clk);
    tests++;
    if (done_cnt - d0 !== 1 || cs_falls !== f0 || rv_cnt !== rv0) begin
      fails++;
      $display("FAIL len0_counts: done=%0d falls=%0d rv=%0d, required 1 0 0",
               done_cnt - d0, cs_falls - f0, rv_cnt - rv0);
    end
  endtask

  task automatic test_patterns();
    for (int t = 0; t < 3; t++) begin
      logic [23:0] a;
      int l, rv0, d0;
      a = 24'($urandom);
      l = $urandom_range(1, 4);
      for (int i = 0; i < l; i++) flash_mem[i] = 8'($urandom);
      rv0 = rv_cnt;
      d0 = done_cnt;
      hdr_bits = '0;
      mosi_err = 0;
      send(a, 16'(l));
      wait_done(d0 + 1, 3000);
      tests++;
      if (hdr_bits !== {8'h03, a} || last_rises !== 32 + 8 * l) begin
        fails++;
        $display("FAIL pattern_frame: hdr=%h rises=%0d, required %h %0d",
                 hdr_bits, last_rises, {8'h03, a}, 32 + 8 * l);
      end
      tests++;
      if (rv_cnt - rv0 !== l || exp_q.size() != 0 || mosi_err != 0) begin
        fails++;
        $display("FAIL pattern_bytes: rv=%0d left=%0d mosi_err=%0d, required %0d 0 0",
                 rv_cnt - rv0, exp_q.size(), mosi_err, l);
      end
    end
  endtask

  task automatic test_abort();
    int rv0 = rv_cnt;
    int d0 = done_cnt;
    int rv1, d1;
    int n = 0;
    flash_mem[0] = 8'h11;
    flash_mem[1] = 8'h22;
    flash_mem[2] = 8'h33;
    send(24'hABCDEF, 16'd3);
    while (rise_cnt < 42 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (rise_cnt < 42) begin
      fails++;
      $display("FAIL abort_timeout: rises=%0d, required 42", rise_cnt);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (spi_cs !== 1'b1 || spi_sck !== 1'b0) begin
      fails++;
      $display("FAIL abort_pins: cs=%b sck=%b, required 1 0", spi_cs, spi_sck);
    end
    rv1 = rv_cnt;
    d1 = done_cnt;
    exp_q.delete();
    reset = 1'b0;
    repeat (200) @(negedge clk);
    tests++;
    if (rv1 - rv0 !== 1 || rv_cnt !== rv1 || done_cnt !== d1 || d1 !== d0) begin
      fails++;
      $display("FAIL abort_quiet: rv before=%0d after=%0d done=%0d, required 1 0 0",
               rv1 - rv0, rv_cnt - rv1, done_cnt - d0);
    end
  endtask

  task automatic test_back_to_back();
    int rv0 = rv_cnt;
    int d0 = done_cnt;
    int f0 = cs_falls;
    int n = 0;
    flash_mem[0] = 8'h5A;
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h5A);
    req_addr = 24'h000040;
    req_len = 16'd1;
    req_valid = 1'b1;
    while (done_cnt < d0 + 2 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    tests++;
    if (done_cnt - d0 !== 2 || rv_cnt - rv0 !== 2 || cs_falls - f0 !== 2) begin
      fails++;
      $display("FAIL b2b_counts: done=%0d rv=%0d falls=%0d, required 2 2 2",
               done_cnt - d0, rv_cnt - rv0, cs_falls - f0);
    end
    tests++;
    if (last_gap < 3) begin
      fails++;
      $display("FAIL b2b_gap: cs high %0d cycles from done, required >= 3",
               last_gap);
    end
    tests++;
    if (ready_err != 0 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL b2b_ready: ready_err=%0d left=%0d, required 0 0",
               ready_err, exp_q.size());
    end
  endtask

  task automatic test_clkdiv1();
    int cs_low = 0, rises = 0, bad_per = 0, rv = 0, last_rise = -1, n = 0;
    logic [31:0] hb = '0;
    logic [7:0] e;
    logic ps = 1'b0;
    bit seen = 1'b0;
    exp1_q.push_back(8'hFF);
    req_addr1 = 24'hFFFFFF;
    req_len1 = 16'd1;
    req_valid1 = 1'b1;
    while (req_ready1 !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1 req_valid1 = 1'b0;
    n = 0;
    while (!seen && n < 500) begin
      @(negedge clk);
      n++;
      if (!spi_cs1) cs_low++;
      if (!ps && spi_sck1 && !spi_cs1) begin
        if (rises < 32) hb = {hb[30:0], spi_mosi1};
        if (last_rise >= 0 && n - last_rise != 2) bad_per++;
        last_rise = n;
        rises++;
      end
      ps = spi_sck1;
      if (rd_valid1) begin
        rv++;
        tests++;
        e = (exp1_q.size() != 0) ? exp1_q.pop_front() : 8'hxx;
        if (rd_data1 !== e) begin
          fails++;
          $display("FAIL div1_rd_data: got %h, required %h", rd_data1, e);
        end
      end
      if (done1) seen = 1'b1;
    end
    tests++;
    if (!seen || cs_low !== 82) begin
      fails++;
      $display("FAIL div1_cs_span: done=%b cs low %0d, required 1 and 82",
               seen, cs_low);
    end
    tests++;
    if (rises !== 40 || bad_per !== 0) begin
      fails++;
      $display("FAIL div1_sck: rises=%0d bad periods=%0d, required 40 0",
               rises, bad_per);
    end
    tests++;
    if (hb !== 32'h03FFFFFF || rv !== 1 || exp1_q.size() != 0) begin
      fails++;
      $display("FAIL div1_frame: hdr=%h rv=%0d left=%0d, required 03ffffff 1 0",
               hb, rv, exp1_q.size());
    end
  endtask

  task automatic test_checker();
    tests++;
    if (viol != 0 || viol1 != 0) begin
      fails++;
      $display("FAIL spi_rules: violations %0d and %0d, required 0 0",
               viol, viol1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_patterns();
    test_clkdiv1();
    test_back_to_back();
    test_abort();
    test_checker();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
